// File: rtl/mode1_ctrl_if.sv
// Control/bus bundle between the softmax top-level controller and the mode-1 sequencer.
// The master side issues start and parameters; the slave side drives SRAM reads and status.
interface mode1_ctrl_if #(
    parameter int ADDRWIDTH = 8
);
    logic                 start;
    logic [ADDRWIDTH-1:0] base_addr;
    logic [ADDRWIDTH-1:0] num_pairs;
    logic                 stall;
    logic                 rd_en;
    logic [ADDRWIDTH-1:0] rd_addr;
    logic                 mode1_run;
    logic                 max_clear;
    logic                 busy;
    logic                 done;
    logic                 max_valid;

    modport master (
        output start, base_addr, num_pairs, stall,
        input  rd_en, rd_addr, mode1_run, max_clear, busy, done, max_valid
    );

    modport slave (
        input  start, base_addr, num_pairs, stall,
        output rd_en, rd_addr, mode1_run, max_clear, busy, done, max_valid
    );
endinterface

// File: rtl/mode1_ctrl.sv
// Sequencer for the mode-1 running-max pass: clear accumulator, stream pairs, pulse done.
// Latency: done at start+N+3 (+1 per READ stall); stall freezes address/count only in READ.
module mode1_ctrl #(
    parameter int ADDRWIDTH = 8
) (
    input  logic        clk,
    input  logic        reset,
    mode1_ctrl_if.slave bus
);
    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_CLEAR = 3'd1;
    localparam logic [2:0] S_READ  = 3'd2;
    localparam logic [2:0] S_DRAIN = 3'd3;
    localparam logic [2:0] S_DONE  = 3'd4;

    logic [2:0]           state_q, state_d;
    logic [ADDRWIDTH-1:0] addr_q, addr_d;
    logic [ADDRWIDTH-1:0] rem_q, rem_d;
    logic                 max_valid_q, max_valid_d;
    logic                 run_q, run_d;
    logic                 rd_en;

    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        rem_d       = rem_q;
        max_valid_d = max_valid_q;
        rd_en       = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    addr_d      = bus.base_addr;
                    rem_d       = bus.num_pairs;
                    max_valid_d = 1'b0;
                    state_d     = S_CLEAR;
                end
            end
            S_CLEAR: begin
                state_d = (rem_q != '0) ? S_READ : S_DONE;
            end
            S_READ: begin
                if (!bus.stall) begin
                    rd_en  = 1'b1;
                    addr_d = addr_q + ADDRWIDTH'(1);
                    rem_d  = rem_q - ADDRWIDTH'(1);
                    if (rem_q == ADDRWIDTH'(1)) begin
                        state_d = S_DRAIN;
                    end
                end
            end
            S_DRAIN: begin
                state_d = S_DONE;
            end
            S_DONE: begin
                max_valid_d = 1'b1;
                state_d     = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
        // Run follows the read by one cycle regardless of state, matching SRAM latency.
        run_d = rd_en;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= S_IDLE;
            addr_q      <= '0;
            rem_q       <= '0;
            max_valid_q <= 1'b0;
            run_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            rem_q       <= rem_d;
            max_valid_q <= max_valid_d;
            run_q       <= run_d;
        end
    end

    assign bus.rd_en     = rd_en;
    assign bus.rd_addr   = addr_q;
    assign bus.mode1_run = run_q;
    assign bus.max_clear = (state_q == S_CLEAR);
    assign bus.busy      = (state_q == S_CLEAR) || (state_q == S_READ) || (state_q == S_DRAIN);
    assign bus.done      = (state_q == S_DONE);
    // Level flag is visible in the done cycle itself, then held by the register.
    assign bus.max_valid = max_valid_q || (state_q == S_DONE);
endmodule

// File: doc/mode1_ctrl.md
# mode1_ctrl

Sequencer for the mode-1 running-max datapath (`mode1_max`) of the softmax engine. On a `start` pulse it clears the max accumulator, streams a vector of packed element pairs from the input SRAM one word per cycle, and drives `mode1_run` aligned with SRAM read data. When the accumulator holds the vector maximum, it signals `done` so the top-level controller can launch the next softmax mode.

## Interface
Parameters:
- `ADDRWIDTH`, default 8: SRAM word-address width. This is also the width of the pair counter.

Ports:
- `clk`  in  1  clock.
- `reset`  in  1  synchronous, active-high reset.
- `start`  in  1  one-cycle request. Sampled only in IDLE.
- `base_addr`  in  ADDRWIDTH  word address of the first pair. Latched on an accepted `start`.
- `num_pairs`  in  ADDRWIDTH  number of SRAM words to read; each word holds two DATAWIDTH elements. Latched on an accepted `start`. 0 is legal.
- `stall`  in  1  memory-port hold request from the SRAM arbiter. Honoured only in READ.
- `rd_en`  out  1  SRAM read enable.
- `rd_addr`  out  ADDRWIDTH  SRAM read address. Read data returns 1 cycle after `rd_en`.
- `mode1_run`  out  1  enable for the `mode1_max` output register.
- `max_clear`  out  1  clears the `mode1_max` accumulator to 0. The top level ORs it into the datapath reset.
- `busy`  out  1  high from CLEAR through DRAIN.
- `done`  out  1  one-cycle pulse; the accumulator output is valid in this cycle.
- `max_valid`  out  1  level signal. Set with `done`, cleared by the next accepted `start` or by `reset`.

## Operation
- States: IDLE, CLEAR, READ, DRAIN, DONE.
- IDLE:
  - `start`=1 latches `base_addr` into the address register and `num_pairs` into the remaining counter `rem`, clears `max_valid`, and moves to CLEAR.
- CLEAR:
  - `max_clear`=1 for exactly 1 cycle.
  - Next state is READ if `rem`≠0, else DONE.
- READ:
  - If `stall`=0: `rd_en`=1, `rd_addr` = address register, then address+1 (mod 2^ADDRWIDTH, wraps silently) and `rem`−1.
  - If `stall`=1: `rd_en`=0; address and `rem` hold.
  - Moves to DRAIN on the cycle a read issues with `rem`=1.
- DRAIN: 1 cycle. Covers the last `mode1_run`. `stall` is ignored. Next state is DONE.
- DONE:
  - `done`=1 and `max_valid` is set. Next state is IDLE.
  - `start` is ignored in DONE.
- `mode1_run` is `rd_en` delayed by one register stage. It is independent of state, so a run always pairs with returned data, including across stalls.
- `busy` = (state ∈ {CLEAR, READ, DRAIN}).
- `start` is ignored whenever state≠IDLE; the latched parameters are not disturbed.

## Timing
- Reset values: state=IDLE, `rd_en`=0, `rd_addr`=0, `mode1_run`=0, `max_clear`=0, `busy`=0, `done`=0, `max_valid`=0, `rem`=0.
- `reset` mid-operation:
  - Returns to IDLE next cycle with all outputs at reset values.
  - The pending `mode1_run` pipeline bit is cleared, so no run fires after reset.
- With `start` accepted at cycle T and N=`num_pairs`≥1 with no stalls:
  - CLEAR at T+1.
  - `rd_en` high T+2..T+N+1.
  - `mode1_run` high T+3..T+N+2.
  - DRAIN at T+N+2.
  - `done` at T+N+3.
  - IDLE at T+N+4, where the next `start` is accepted.
- Each stall cycle delays every subsequent event by exactly 1 cycle.
- N=0: CLEAR at T+1, `done` at T+2. `rd_en` and `mode1_run` are never asserted, and the accumulator stays 0.
- Throughput: one pair per cycle while READ is unstalled. Per-vector overhead is 4 cycles (start-accept through return to IDLE).
- `max_clear` and `mode1_run` are never high in the same cycle.

## Test plan
- Reset, then `start` with `base_addr`=0x10, N=4 and SRAM pairs (1,2),(7,3),(−5,4),(6,0):
  - `rd_addr` 0x10..0x13 at T+2..T+5.
  - `mode1_run` at T+3..T+6.
  - `done` at T+7 with datapath outp=7.0; `max_valid`=1.
- Same vector with `stall`=1 at T+3 and T+4:
  - `rd_addr` holds 0x11 for 2 cycles; `rd_en`=0 during the stall.
  - `mode1_run` shows a 2-cycle gap.
  - `done` at T+9; outp=7.0.
- N=0:
  - `max_clear` at T+1, `done` at T+2.
  - No `rd_en` and no `mode1_run`; outp=0.
- `base_addr`=0xFE, N=3: `rd_addr` sequence 0xFE, 0xFF, 0x00; `done` at T+6.
- `start` pulsed during READ and again during DONE: both are ignored, and a `start` at T+N+4 is accepted with a fresh CLEAR.
- `reset` asserted at T+4 of an N=8 run:
  - All outputs 0 at T+5, with no `mode1_run` at T+5.
  - `max_valid`=0.
  - A new `start` after reset completes normally.
